// File: rtl/lfclk_rst_seq_pkg.sv
// Shared definitions for lfclk_rst_seq: sequencer state encoding and divider sizing.
package lfclk_rst_seq_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } seq_state_e;

    function automatic int unsigned acc_width(input int unsigned clk_hz);
        return $clog2(clk_hz) + 1;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer; output resets to 0.
module sync_debounce #(
    parameter int unsigned DEB_CYCLES = 16000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // Counter only runs while the synchronized level disagrees with the output.
    always_comb begin
        sync_d = {sync_q[0], din};
        cnt_d  = '0;
        deb_d  = deb_q;
        if (sync_q[1] != deb_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                deb_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            deb_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            deb_q  <= deb_d;
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/lfclk_rst_seq.sv
// Fractional LF clock divider plus debounced SoC AON reset / wakeup conditioning.
// Define LFCLK_RST_SEQ_WAKE_DEB_EN to debounce the wakeup pin as well as the button.
module lfclk_rst_seq
    import lfclk_rst_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 16000000,
    parameter int unsigned LF_HZ      = 32768,
    parameter int unsigned DEB_CYCLES = 16000,
    parameter int unsigned HOLD_LF    = 8
) (
    input  logic       clk_16M,
    input  logic       reset_periph,
    input  logic       btn_rst_n,
    input  logic       wakeup_raw,
    output logic       lfclk,
    output logic       lf_tick,
    output logic       soc_erst_n,
    output logic       dwakeup_n,
    output logic [1:0] seq_state
);
    localparam int unsigned   AW   = acc_width(CLK_HZ);
    localparam logic [AW-1:0] STEP = AW'(2 * LF_HZ);
    localparam logic [AW-1:0] MOD  = AW'(CLK_HZ);
    localparam int unsigned   HW   = (HOLD_LF > 1) ? $clog2(HOLD_LF) : 1;

    logic btn_deb;
    logic wake_cond;

    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_btn_deb (
        .clk  (clk_16M),
        .rst  (reset_periph),
        .din  (btn_rst_n),
        .dout (btn_deb)
    );

`ifdef LFCLK_RST_SEQ_WAKE_DEB_EN
    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_wake_deb (
        .clk  (clk_16M),
        .rst  (reset_periph),
        .din  (wakeup_raw),
        .dout (wake_cond)
    );
`else
    logic [1:0] wake_sync_q, wake_sync_d;

    always_comb begin
        wake_sync_d = {wake_sync_q[0], wakeup_raw};
    end

    always_ff @(posedge clk_16M) begin
        if (reset_periph) begin
            wake_sync_q <= '0;
        end else begin
            wake_sync_q <= wake_sync_d;
        end
    end

    assign wake_cond = wake_sync_q[1];
`endif

    logic [AW-1:0] acc_q, acc_d, acc_sum;
    logic          lfclk_q, lfclk_d;
    logic          lf_tick_q, lf_tick_d;
    logic          dwakeup_n_q, dwakeup_n_d;

    always_comb begin
        acc_sum   = acc_q + STEP;
        acc_d     = acc_sum;
        lfclk_d   = lfclk_q;
        lf_tick_d = 1'b0;
        if (acc_sum >= MOD) begin
            acc_d     = acc_sum - MOD;
            lfclk_d   = ~lfclk_q;
            lf_tick_d = ~lfclk_q;
        end
        dwakeup_n_d = ~wake_cond;
    end

    always_ff @(posedge clk_16M) begin
        if (reset_periph) begin
            acc_q       <= '0;
            lfclk_q     <= 1'b0;
            lf_tick_q   <= 1'b0;
            dwakeup_n_q <= 1'b1;
        end else begin
            acc_q       <= acc_d;
            lfclk_q     <= lfclk_d;
            lf_tick_q   <= lf_tick_d;
            dwakeup_n_q <= dwakeup_n_d;
        end
    end

    seq_state_e    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          erst_n_q, erst_n_d;

    // erst_n is registered from the next state so it is high exactly while in S_RUN.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (!btn_deb) begin
            state_d = S_RST;
            hold_d  = '0;
        end else begin
            case (state_q)
                S_RST: begin
                    state_d = S_HOLD;
                    hold_d  = '0;
                end
                S_HOLD: begin
                    if (lf_tick_q) begin
                        if (hold_q == HW'(HOLD_LF - 1)) begin
                            state_d = S_RUN;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                S_RUN: state_d = S_RUN;
                default: begin
                    state_d = S_RST;
                    hold_d  = '0;
                end
            endcase
        end
        erst_n_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk_16M) begin
        if (reset_periph) begin
            state_q  <= S_RST;
            hold_q   <= '0;
            erst_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            erst_n_q <= erst_n_d;
        end
    end

    assign lfclk      = lfclk_q;
    assign lf_tick    = lf_tick_q;
    assign soc_erst_n = erst_n_q;
    assign dwakeup_n  = dwakeup_n_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_lfclk_rst_seq.sv
// Self-checking bench for lfclk_rst_seq; CLK_HZ/LF_HZ = 15625/32 keeps the 16 MHz / 32768 ratio.
`timescale 1ns/1ps
module tb_lfclk_rst_seq;

    localparam int unsigned CLK_HZ = 15625;
    localparam int unsigned LF_HZ  = 32;

    logic       clk_16M = 1'b0;
    logic       reset_periph;
    logic       btn_rst_n;
    logic       wakeup_raw;
    logic       lfclk;
    logic       lf_tick;
    logic       soc_erst_n;
    logic       dwakeup_n;
    logic [1:0] seq_state;

    int checks   = 0;
    int failures = 0;

    lfclk_rst_seq #(
        .CLK_HZ     (CLK_HZ),
        .LF_HZ      (LF_HZ),
        .DEB_CYCLES (4),
        .HOLD_LF    (2)
    ) dut (
        .clk_16M      (clk_16M),
        .reset_periph (reset_periph),
        .btn_rst_n    (btn_rst_n),
        .wakeup_raw   (wakeup_raw),
        .lfclk        (lfclk),
        .lf_tick      (lf_tick),
        .soc_erst_n   (soc_erst_n),
        .dwakeup_n    (dwakeup_n),
        .seq_state    (seq_state)
    );

    always #5 clk_16M = ~clk_16M;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_16M);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] st, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!ok) begin
                step();
                if (seq_state === st) ok = 1'b1;
            end
        end
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!ok) begin
                step();
                if (lf_tick === 1'b1) ok = 1'b1;
            end
        end
    endtask

`ifndef LFCLK_RST_SEQ_WAKE_DEB_EN
    typedef struct {
        logic wake;
        logic exp_dwn;
    } wake_vec_t;
    localparam int NV = 16;
    wake_vec_t  vec [NV];
    logic       exp_q [$];
`endif

    initial begin
        bit   ok;
        int   last_tog, first_tog, ticks, toggles, bad_gap, bad_tick, bad, found;
        logic prev;
`ifndef LFCLK_RST_SEQ_WAKE_DEB_EN
        logic [NV-1:0] pat;
        pat = 16'b1000_1101_0111_0010;
        for (int i = 0; i < NV; i++) begin
            vec[i].wake    = pat[i];
            vec[i].exp_dwn = ~pat[i];
        end
`endif
        reset_periph = 1'b1;
        btn_rst_n    = 1'b0;
        wakeup_raw   = 1'b0;
        repeat (3) step();
        chk("rst_lfclk", lfclk, 0);
        chk("rst_lf_tick", lf_tick, 0);
        chk("rst_erst_n", soc_erst_n, 0);
        chk("rst_dwakeup_n", dwakeup_n, 1);
        chk("rst_state", seq_state, 0);

        // One simulated "second" of the scaled clock with the button held.
        reset_periph = 1'b0;
        last_tog = 0; first_tog = 0; ticks = 0; toggles = 0;
        bad_gap = 0; bad_tick = 0; prev = 1'b0;
        for (int k = 1; k <= int'(CLK_HZ); k++) begin
            step();
            if (lfclk !== prev) begin
                if (first_tog == 0) first_tog = k;
                if ((k - last_tog) != 244 && (k - last_tog) != 245) bad_gap++;
                last_tog = k;
                toggles++;
            end
            if (lf_tick !== (lfclk & ~prev)) bad_tick++;
            if (lf_tick === 1'b1) ticks++;
            prev = lfclk;
        end
        chk("first_toggle", first_tog, 245);
        chk("tick_count", ticks, 32);
        chk("toggle_count", toggles, 64);
        chk("last_toggle", last_tog, CLK_HZ);
        chk("gap_violations", bad_gap, 0);
        chk("tick_alignment", bad_tick, 0);
        chk("held_state", seq_state, 0);

        // Button release: debouncer and hold sequence timing.
        btn_rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 5) chk("btn_deb_t5", dut.btn_deb, 0);
            if (k == 6) begin
                chk("btn_deb_t6", dut.btn_deb, 1);
                chk("state_t6", seq_state, 0);
            end
            if (k == 7) chk("state_t7_hold", seq_state, 1);
        end
        wait_tick(ok);
        chk("hold_tick1_seen", ok, 1);
        step();
        chk("hold_after_tick1", seq_state, 1);
        wait_tick(ok);
        chk("hold_tick2_seen", ok, 1);
        chk("tick2_state", seq_state, 1);
        chk("tick2_erst_n", soc_erst_n, 0);
        step();
        chk("run_state", seq_state, 2);
        chk("run_erst_n", soc_erst_n, 1);

        // Three-cycle glitch while running must be ignored.
        bad = 0;
        btn_rst_n = 1'b0;
        for (int i = 0; i < 23; i++) begin
            step();
            if (seq_state !== 2'd2 || soc_erst_n !== 1'b1) bad++;
            if (i == 2) btn_rst_n = 1'b1;
        end
        chk("glitch_run_bad_cycles", bad, 0);

        // Press mid-hold restarts the full hold.
        btn_rst_n = 1'b0;
        wait_state(2'd0, ok);
        chk("press_to_rst", ok, 1);
        chk("press_erst_n", soc_erst_n, 0);
        btn_rst_n = 1'b1;
        wait_state(2'd1, ok);
        chk("release_to_hold", ok, 1);
        wait_tick(ok);
        chk("mid_hold_tick", ok, 1);
        btn_rst_n = 1'b0;
        wait_state(2'd0, ok);
        chk("mid_hold_press_rst", ok, 1);
        btn_rst_n = 1'b1;
        wait_state(2'd1, ok);
        chk("rehold_entry", ok, 1);
        wait_tick(ok);
        chk("rehold_tick1_seen", ok, 1);
        step();
        chk("rehold_after_tick1", seq_state, 1);
        wait_tick(ok);
        chk("rehold_tick2_seen", ok, 1);
        step();
        chk("rehold_run_state", seq_state, 2);
        chk("rehold_run_erst_n", soc_erst_n, 1);

        // One-cycle peripheral reset while running, with wake and lfclk high.
        wakeup_raw = 1'b1;
        repeat (10) step();
        chk("wake_before_rst", dwakeup_n, 0);
        found = 0;
        for (int i = 0; i < 600; i++) begin
            if (found == 0) begin
                step();
                if (lfclk === 1'b1) found = 1;
            end
        end
        chk("lfclk_high_seen", found, 1);
        reset_periph = 1'b1;
        step();
        reset_periph = 1'b0;
        wakeup_raw   = 1'b0;
        chk("prst_erst_n", soc_erst_n, 0);
        chk("prst_lfclk", lfclk, 0);
        chk("prst_lf_tick", lf_tick, 0);
        chk("prst_state", seq_state, 0);
        chk("prst_dwakeup_n", dwakeup_n, 1);
        found = 0;
        for (int k = 1; k <= 300; k++) begin
            if (found == 0) begin
                step();
                if (lfclk === 1'b1) found = k;
            end
        end
        chk("resume_first_toggle", found, 245);

`ifndef LFCLK_RST_SEQ_WAKE_DEB_EN
        // Wakeup passes through the synchronizer with a fixed 3-cycle latency.
        exp_q.delete();
        for (int i = 0; i < NV + 2; i++) begin
            if (i < NV) begin
                wakeup_raw = vec[i].wake;
                exp_q.push_back(vec[i].exp_dwn);
            end else begin
                wakeup_raw = 1'b0;
                exp_q.push_back(1'b1);
            end
            step();
            if (exp_q.size() == 3) chk("wake_vec", dwakeup_n, exp_q.pop_front());
        end
`else
        repeat (10) step();
        bad = 0;
        wakeup_raw = 1'b1;
        for (int i = 0; i < 14; i++) begin
            step();
            if (i == 1) wakeup_raw = 1'b0;
            if (dwakeup_n !== 1'b1) bad++;
        end
        chk("wake_short_pulse_ignored", bad, 0);
        found = 0;
        wakeup_raw = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step();
            if (i == 5) wakeup_raw = 1'b0;
            if (dwakeup_n === 1'b0) found = 1;
        end
        chk("wake_long_pulse_seen", found, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfclk_rst_seq.md
LFCLK_RST_SEQ -- requirements
Module: lfclk_rst_seq

Interface
REQ-001 SHALL have parameter CLK_HZ, default 16000000: frequency of clk_16M in Hz.
REQ-002 SHALL have parameter LF_HZ, default 32768: target low-frequency clock in Hz.
REQ-003 SHALL have parameter DEB_CYCLES, default 16000: stable-input cycles required by each debouncer (1 ms at 16 MHz).
REQ-004 SHALL have parameter HOLD_LF, default 8: lfclk rising edges between button release and erst_n release.
REQ-005 SHALL have port clk_16M, input, 1 bit: the only clock.
REQ-006 SHALL have port reset_periph, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port btn_rst_n, input, 1 bit: raw asynchronous reset button, low = pressed.
REQ-008 SHALL have port wakeup_raw, input, 1 bit: raw asynchronous wakeup pin, high = wake.
REQ-009 SHALL have port lfclk, output, 1 bit: approximately 50 % duty clock averaging exactly LF_HZ, to be fed through BUFG into lfextclk.
REQ-010 SHALL have port lf_tick, output, 1 bit: one-cycle pulse in the cycle lfclk goes 0->1.
REQ-011 SHALL have port soc_erst_n, output, 1 bit: SoC AON reset, low = in reset.
REQ-012 SHALL have port dwakeup_n, output, 1 bit: conditioned wakeup, low = wake request.
REQ-013 SHALL have port seq_state, output, 2 bits: FSM state code, for debug.

Function
REQ-014 SHALL pass btn_rst_n and wakeup_raw through a 2-FF synchronizer each before any other logic.
REQ-015 SHALL implement the fractional divider as: accumulator acc of width clog2(CLK_HZ)+1; each cycle, if acc + 2*LF_HZ >= CLK_HZ then acc <= acc + 2*LF_HZ - CLK_HZ and lfclk toggles, else acc <= acc + 2*LF_HZ.
REQ-016 SHALL produce zero long-term drift with the REQ-015 scheme; with default parameters, successive toggles are 244 or 245 cycles apart.
REQ-017 SHALL assert lf_tick in the same cycle the registered lfclk becomes 1, and never in any other cycle.
REQ-018 SHALL make the reset debouncer output btn_deb change only after the synchronized input has differed from btn_deb for DEB_CYCLES consecutive cycles; any intervening glitch restarts the counter from 0.
REQ-019 SHALL implement FSM states S_RST=0, S_HOLD=1, S_RUN=2; code 3 is unreachable and SHALL decode to S_RST.
REQ-020 SHALL transition S_RST->S_HOLD when btn_deb=1, with the hold counter cleared.
REQ-021 SHALL, in S_HOLD, increment the hold counter on each lf_tick and go to S_RUN in the cycle the HOLD_LF-th tick occurs.
REQ-022 SHALL return any state to S_RST in the next cycle when btn_deb=0, clearing the hold counter; a press mid-S_HOLD restarts the full hold.
REQ-023 SHALL drive soc_erst_n as a registered output equal to 1 only in S_RUN; it SHALL go 1 the cycle after the S_RUN entry edge.
REQ-024 SHALL drive dwakeup_n as the registered inverse of the conditioned wakeup signal.

Reset
REQ-025 SHALL, while reset_periph=1 at a clk_16M edge, set: acc=0, lfclk=0, lf_tick=0, both sync chains and btn_deb to 0, debounce counters to 0, FSM=S_RST, soc_erst_n=0, dwakeup_n=1.
REQ-026 SHALL resume lfclk from phase 0 on the first cycle after reset_periph deasserts, with the first toggle after 245 cycles at default parameters.

Configuration
REQ-027 SHALL, when macro LFCLK_RST_SEQ_WAKE_DEB_EN is defined, debounce the synchronized wakeup with a second REQ-018-style debouncer (reset value 0).
REQ-028 SHALL, when LFCLK_RST_SEQ_WAKE_DEB_EN is undefined, condition wakeup by the 2-FF synchronizer only, so dwakeup_n follows wakeup_raw after 3 cycles.

Structure
REQ-029 SHALL define the FSM state encoding and the accumulator-width function in the shared package lfclk_rst_seq_pkg.
REQ-030 SHALL implement the debouncer as sub-module sync_debounce (synchronizer plus counter, parameter DEB_CYCLES), instantiated once, or twice when LFCLK_RST_SEQ_WAKE_DEB_EN is defined.

Verification
REQ-031 SHALL verify, at default parameters, that 1 s of simulated clk_16M (16000000 cycles) after reset yields exactly 32768 lf_tick pulses with every toggle gap in {244, 245}.
REQ-032 SHALL verify, with DEB_CYCLES=4 and HOLD_LF=2, that btn_rst_n rising at t0 gives btn_deb=1 at t0+2+4 cycles, then soc_erst_n=1 one cycle after the 2nd subsequent lf_tick.
REQ-033 SHALL verify that a 3-cycle low glitch on btn_rst_n with DEB_CYCLES=4 while in S_RUN leaves soc_erst_n=1 and seq_state=2 throughout.
REQ-034 SHALL verify that a button press held 4+ cycles after S_HOLD has seen 1 tick moves to S_RST, and that after release the full HOLD_LF=2 ticks are needed again.
REQ-035 SHALL verify that asserting reset_periph for 1 cycle in S_RUN gives, next cycle, soc_erst_n=0, lfclk=0, seq_state=0, dwakeup_n=1.
REQ-036 SHALL verify the wakeup path: with the macro undefined, a wakeup_raw pulse makes dwakeup_n=0 3 cycles later; with the macro defined and DEB_CYCLES=4, a 2-cycle pulse is ignored and a 6-cycle pulse produces dwakeup_n=0.
